count_ones_d: RTL and testbench

COUNT_ONES_D -- requirements
Module: count_ones_d

---
 rtl/count_ones_d.sv | 47 ++++
 tb/tb_count_ones_d.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/count_ones_d.sv
// count_ones_d: serial popcount, one data bit per clock, result registered on bit_count.
// Define COUNT_ONES_EARLY_EXIT_EN to finish as soon as the remaining shifted word is zero.
module count_ones_d #(
  parameter int data_width  = 4,
  parameter int count_width = 3
) (
  output logic [count_width-1:0] bit_count,
  input  logic [data_width-1:0]  data,
  input  logic                   clk,
  input  logic                   reset
);
  localparam int IW = data_width > 1 ? $clog2(data_width) : 1;
  typedef enum logic {IDLE, COUNTING} state_t;
  state_t                 r_state;
  logic [data_width-1:0]  r_temp;
  logic [count_width-1:0] r_acc;
  logic [IW-1:0]          r_idx;
  logic [count_width-1:0] w_sum;
  logic                   w_last;
  assign w_sum = r_acc + count_width'(r_temp[0]);
`ifdef COUNT_ONES_EARLY_EXIT_EN
  assign w_last = (r_temp >> 1) == '0 || r_idx == IW'(data_width - 1);
`else
  assign w_last = r_idx == IW'(data_width - 1);
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      bit_count <= '0;
      r_acc     <= '0;
      r_temp    <= '0;
      r_idx     <= '0;
    end else if (r_state == IDLE) begin
      r_temp  <= data;
      r_acc   <= '0;
      r_idx   <= '0;
      r_state <= COUNTING;
    end else if (w_last) begin
      bit_count <= w_sum;
      r_state   <= IDLE;
    end else begin
      r_acc  <= w_sum;
      r_temp <= r_temp >> 1;
      r_idx  <= r_idx + IW'(1);
    end
  end
endmodule

// File: tb/tb_count_ones_d.sv
// tb_count_ones_d: directed and random popcount checks against a timeline model of conversions.
module tb_count_ones_d;
  logic       clk = 0;
  logic       reset = 0;
  logic [3:0] data = 0;
  logic [2:0] bit_count;
  int n_err = 0;
  int n_chk = 0;
  logic chk_en = 0;
  int   m_rem = 0;
  logic [2:0] m_val = 0;
  logic [2:0] m_exp = 0;

  count_ones_d dut (.bit_count(bit_count), .data(data), .clk(clk), .reset(reset));

  always #5 clk = ~clk;

  function automatic int lat(logic [3:0] d);
`ifdef COUNT_ONES_EARLY_EXIT_EN
    int hb = 0;
    for (int i = 0; i < 4; i++) if (d[i]) hb = i;
    return hb + 1;
`else
    return 4;
`endif
  endfunction

  // A conversion occupies the load edge plus lat() further edges; result lands on the last.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_exp = 0;
      m_rem = 0;
    end else if (m_rem == 0) begin
      m_val = 3'($countones(data));
      m_rem = lat(data);
    end else begin
      m_rem--;
      if (m_rem == 0) m_exp = m_val;
    end
  end

  always @(negedge clk) if (chk_en) begin
    n_chk++;
    if (bit_count !== m_exp) begin
      n_err++;
      $display("FAIL model t=%0t got=%0d want=%0d data=%h", $time, bit_count, m_exp, data);
    end
  end

  task automatic chk(string name, logic [2:0] got, logic [2:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic rst_load(logic [3:0] d);
    @(posedge clk);
    #2;
    reset = 0;
    data = d;
    edges(1);
    reset = 1;
  endtask

  logic [3:0] vec [7] = '{4'h3, 4'h5, 4'hB, 4'h9, 4'hC, 4'hD, 4'h7};
  logic [2:0] res [7] = '{3'd2, 3'd2, 3'd3, 3'd2, 3'd2, 3'd3, 3'd3};

  initial begin
    @(posedge clk);
    #2;
    chk_en = 1;
    chk("reset_state", bit_count, 3'd0);
    reset = 1;
    rst_load(4'hF);
    edges(4);
    chk("f_edge4", bit_count, 3'd0);
    edges(1);
    chk("f_edge5", bit_count, 3'd4);
    for (int i = 0; i < 7; i++) begin
      rst_load(vec[i]);
      edges(6);
      chk($sformatf("vec_%h", vec[i]), bit_count, res[i]);
    end
    rst_load(4'h0);
    edges(6);
    chk("zero", bit_count, 3'd0);
    rst_load(4'hF);
    edges(6);
    chk("ones", bit_count, 3'd4);
    edges(2);
    reset = 0;
    #1;
    chk("abort_async", bit_count, 3'd0);
    edges(1);
    reset = 1;
    edges(4);
    chk("abort_edge4", bit_count, 3'd0);
    edges(1);
    chk("abort_edge5", bit_count, 3'd4);
    rst_load(4'h7);
    edges(1);
    data = 4'h0;
    edges(4);
    chk("ignore_change", bit_count, 3'd3);
    edges(10);
    chk("next_zero", bit_count, 3'd0);
`ifdef COUNT_ONES_EARLY_EXIT_EN
    rst_load(4'h1);
    edges(2);
    chk("early_1_edge2", bit_count, 3'd1);
    rst_load(4'h8);
    edges(4);
    chk("early_8_edge4", bit_count, 3'd0);
    edges(1);
    chk("early_8_edge5", bit_count, 3'd1);
`endif
    repeat (600) begin
      @(posedge clk);
      #2;
      data = 4'($urandom);
      if ($urandom_range(0, 60) == 0) begin
        reset = 0;
        #1;
        chk("rnd_async", bit_count, 3'd0);
        @(posedge clk);
        #2;
        reset = 1;
      end
    end
    edges(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
